simmem_delay_scheduler: RTL and testbench
=========================================

# simmem_delay_scheduler

Timing scheduler for the simulated memory. It accepts write-address and read-address requests, one at a time, and arbitrates between them round-robin. It models a single DRAM row buffer to compute each request's access cost from the package costs, counts that cost down, then emits a release token carrying the request ID and direction. It sits between the AXI address channels and the response banks, which use the release token to time out their stored responses.

## Interface
Parameters:
- RowHitCost, default simmem_pkg::RowHitCost (10): cycles for an open-row hit; must be ≥1.
- PrechargeCost, default simmem_pkg::PrechargeCost (50): cycles to close a mismatching open row.
- ActivationCost, default simmem_pkg::ActivationCost (45): cycles to open a row.
- RowBufferLenWidth, default simmem_pkg::RowBufferLenWidth (8): log2 of the row length in address units.

Ports:
- clk_i, in, 1: clock. Single clock.
- rst_i, in, 1: synchronous, active-high reset.
- waddr_i, in, waddr_req_t: write-address request.
- waddr_valid_i, in, 1: waddr_i valid.
- waddr_ready_o, out, 1: write request accepted.
- raddr_i, in, raddr_req_t: read-address request.
- raddr_valid_i, in, 1: raddr_i valid.
- raddr_ready_o, out, 1: read request accepted.
- release_valid_o, out, 1: release token valid.
- release_ready_i, in, 1: consumer takes the token.
- release_id_o, out, IDWidth: ID of the released request.
- release_is_write_o, out, 1: 1 for a write release, 0 for a read release.
- row_open_o, out, 1: the row buffer holds an open row.
- open_row_o, out, AxAddrWidth-RowBufferLenWidth: currently open row (addr >> RowBufferLenWidth).

## Operation
- FSM states:
  - IDLE: the only state that accepts a request. On a handshake, go to SERVE.
  - SERVE: decrement the counter each cycle. When the counter is 1, go to RELEASE.
  - RELEASE: hold release_valid_o=1. When release_ready_i=1, go to IDLE.
- Arbitration (IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the side named by the priority bit.
  - After each grant, the priority bit points to the non-granted side.
  - Reset priority is write.
  - waddr_ready_o / raddr_ready_o are combinational: state==IDLE && granted. Both are never high in the same cycle.
- Cost, evaluated on the granted address (row = addr[AxAddrWidth-1:RowBufferLenWidth]):
  - Row open and row equal: RowHitCost.
  - No row open: ActivationCost+RowHitCost.
  - Row open and row different: PrechargeCost+ActivationCost+RowHitCost.
- Counter width is CostWidth = $clog2(PrechargeCost+ActivationCost+RowHitCost+1) (7 at defaults). The sum must never truncate.
- On a handshake, register: the counter (loaded with the cost), ID, direction, open_row_o ← row, row_open_o ← 1.
- AxLen, size, burst and the other AxI fields do not affect the cost.
- Release outputs are registered. They must stay stable while release_valid_o=1 and release_ready_i=0.

## Timing
- Request handshake in cycle t → release_valid_o first high in cycle t+cost+1.
  - Example: row hit with defaults → t+11.
- Release handshake in cycle u → state is IDLE in u+1, so the next request can handshake in u+1.
- Maximum throughput is one request per cost+2 cycles.
- Reset values: release_valid_o=0, release_id_o=0, release_is_write_o=0, row_open_o=0, open_row_o=0, both ready outputs 0 during the reset cycle, state IDLE, priority=write.
- Reset mid-SERVE or mid-RELEASE:
  - The in-flight request is dropped and no token is emitted.
  - The row is closed.
  - The first cycle after reset is IDLE.
- A valid arriving during SERVE/RELEASE waits with ready=0; its request must stay stable (AXI rule).
- Back-pressure in RELEASE is unbounded. No further request is accepted until the token drains.

## Structure
- simmem_pkg additions:
  - typedef enum delay_sched_state_e {IDLE, SERVE, RELEASE}.
  - localparam RowWidth = AxAddrWidth-RowBufferLenWidth.
  - localparam CostWidth.
- Existing waddr_req_t, raddr_req_t and IDWidth are reused from simmem_pkg.
- One sub-module: simmem_ax_arbiter, a 2-way round-robin arbiter. Inputs: two valids, advance-on-grant, synchronous reset. Outputs: grant_w, grant_r.

## Test plan
- After reset, one read to addr 0x1234 with ID 3 → cost 55 (activation+hit). release_valid_o rises at t+56 with ID 3 and is_write 0. Afterwards open_row_o=0x12 and row_open_o=1.
- Follow with a write to 0x12F0, ID 5 → row hit, release at t+11, is_write 1. Then a read to 0x3400 → precharge path, release at t+106.
- waddr_valid_i and raddr_valid_i held high continuously → grants alternate W,R,W,R starting with W. Never both ready in one cycle.
- Hold release_ready_i=0 for 20 cycles in RELEASE → outputs stable, both ready outputs 0, no second acceptance. Raise ready → next request accepted the following cycle.
- Assert rst_i during SERVE (counter mid-count) → no release ever appears for that request. row_open_o=0 and release_valid_o=0 after reset. A new request pays ActivationCost+RowHitCost.
- Release handshake and a new valid in the same cycle → no acceptance in that cycle. Acceptance in the next cycle.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared types and timing constants for the simulated memory.
package simmem_pkg;

  // AXI address-channel field widths.
  localparam int unsigned IDWidth       = 6;
  localparam int unsigned AxAddrWidth   = 32;
  localparam int unsigned AxLenWidth    = 8;
  localparam int unsigned AxSizeWidth   = 3;
  localparam int unsigned AxBurstWidth  = 2;
  localparam int unsigned AxLockWidth   = 1;
  localparam int unsigned AxCacheWidth  = 4;
  localparam int unsigned AxProtWidth   = 3;
  localparam int unsigned AxQoSWidth    = 4;
  localparam int unsigned AxRegionWidth = 4;

  // DRAM row-buffer timing model, in clock cycles.
  localparam int unsigned RowHitCost        = 10;
  localparam int unsigned PrechargeCost     = 50;
  localparam int unsigned ActivationCost    = 45;
  localparam int unsigned RowBufferLenWidth = 8;

  // Row number is the address with the in-row offset stripped.
  localparam int unsigned RowWidth  = AxAddrWidth - RowBufferLenWidth;
  // Wide enough for the worst-case (row conflict) cost without truncation.
  localparam int unsigned CostWidth =
      $clog2(PrechargeCost + ActivationCost + RowHitCost + 1);

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AxAddrWidth-1:0]   addr;
    logic [AxLenWidth-1:0]    len;
    logic [AxSizeWidth-1:0]   size;
    logic [AxBurstWidth-1:0]  burst;
    logic [AxLockWidth-1:0]   lock;
    logic [AxCacheWidth-1:0]  cache;
    logic [AxProtWidth-1:0]   prot;
    logic [AxQoSWidth-1:0]    qos;
    logic [AxRegionWidth-1:0] region;
  } waddr_req_t;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AxAddrWidth-1:0]   addr;
    logic [AxLenWidth-1:0]    len;
    logic [AxSizeWidth-1:0]   size;
    logic [AxBurstWidth-1:0]  burst;
    logic [AxLockWidth-1:0]   lock;
    logic [AxCacheWidth-1:0]  cache;
    logic [AxProtWidth-1:0]   prot;
    logic [AxQoSWidth-1:0]    qos;
    logic [AxRegionWidth-1:0] region;
  } raddr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RELEASE
  } delay_sched_state_e;

endpackage

// File: rtl/simmem_ax_arbiter.sv
// Two-way round-robin arbiter between the write and read address channels.
// The priority bit only moves when the grant is actually taken (advance).
module simmem_ax_arbiter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_w,
  input  logic valid_r,
  input  logic advance,
  output logic grant_w,
  output logic grant_r
);

  // 1: write side wins a tie, 0: read side wins a tie.
  logic prio_w_q;

  // Grant the lone requester, or the prioritised side on a tie.
  always_comb begin
    grant_w = valid_w && (!valid_r || prio_w_q);
    grant_r = valid_r && (!valid_w || !prio_w_q);
  end

  // After a taken grant, hand priority to the side that was not granted.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      prio_w_q <= 1'b1;
    end else if (advance) begin
      prio_w_q <= grant_r;
    end
  end

endmodule

// File: rtl/simmem_delay_scheduler.sv
// Timing scheduler: accepts one write or read address request at a time,
// charges it a DRAM row-buffer access cost, counts the cost down and then
// hands a release token (ID + direction) to the response banks.
module simmem_delay_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned RowHitCost        = simmem_pkg::RowHitCost,
  parameter int unsigned PrechargeCost     = simmem_pkg::PrechargeCost,
  parameter int unsigned ActivationCost    = simmem_pkg::ActivationCost,
  parameter int unsigned RowBufferLenWidth = simmem_pkg::RowBufferLenWidth
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,

  input  waddr_req_t                               waddr_i,
  input  logic                                     waddr_valid_i,
  output logic                                     waddr_ready_o,

  input  raddr_req_t                               raddr_i,
  input  logic                                     raddr_valid_i,
  output logic                                     raddr_ready_o,

  output logic                                     release_valid_o,
  input  logic                                     release_ready_i,
  output logic [IDWidth-1:0]                       release_id_o,
  output logic                                     release_is_write_o,

  output logic                                     row_open_o,
  output logic [AxAddrWidth-RowBufferLenWidth-1:0] open_row_o
);

  localparam int unsigned RowW    = AxAddrWidth - RowBufferLenWidth;
  localparam int unsigned MaxCost = PrechargeCost + ActivationCost + RowHitCost;
  localparam int unsigned CostW   = $clog2(MaxCost + 1);

  typedef logic [CostW-1:0] cost_t;
  typedef logic [RowW-1:0]  row_t;

  // Sums are formed at integer width, then narrowed to a width sized for
  // the largest of them, so none of the three costs can wrap.
  localparam cost_t HitCost      = cost_t'(RowHitCost);
  localparam cost_t MissCost     = cost_t'(ActivationCost + RowHitCost);
  localparam cost_t ConflictCost = cost_t'(MaxCost);

  delay_sched_state_e state_q, state_d;
  cost_t              cnt_q, cnt_d;
  cost_t              grant_cost;
  row_t               grant_row;
  logic [IDWidth-1:0] grant_id;
  logic               grant_w, grant_r;
  logic               accept;

  logic [IDWidth-1:0] id_q;
  logic               is_write_q;
  logic               release_valid_q, release_valid_d;
  logic               row_open_q;
  row_t               open_row_q;

  simmem_ax_arbiter u_arbiter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_w (waddr_valid_i),
    .valid_r (raddr_valid_i),
    .advance (accept),
    .grant_w (grant_w),
    .grant_r (grant_r)
  );

  // Ready is gated by reset so nothing is accepted in the reset cycle.
  assign waddr_ready_o = !rst_i && (state_q == IDLE) && grant_w;
  assign raddr_ready_o = !rst_i && (state_q == IDLE) && grant_r;
  assign accept        = waddr_ready_o || raddr_ready_o;

  // Pick the granted request's row/ID and price it against the row buffer.
  always_comb begin
    grant_row = grant_w ? waddr_i.addr[AxAddrWidth-1:RowBufferLenWidth]
                        : raddr_i.addr[AxAddrWidth-1:RowBufferLenWidth];
    grant_id  = grant_w ? waddr_i.id : raddr_i.id;
    if (!row_open_q) begin
      grant_cost = MissCost;
    end else if (grant_row == open_row_q) begin
      grant_cost = HitCost;
    end else begin
      grant_cost = ConflictCost;
    end
  end

  // Next-state and counter logic for IDLE -> SERVE -> RELEASE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SERVE;
          cnt_d   = grant_cost;
        end
      end
      SERVE: begin
        cnt_d = cnt_q - cost_t'(1);
        if (cnt_q == cost_t'(1)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (release_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    release_valid_d = (state_d == RELEASE);
  end

  // State, counter, release token and row-buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      release_valid_q <= 1'b0;
      id_q            <= '0;
      is_write_q      <= 1'b0;
      row_open_q      <= 1'b0;
      open_row_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      release_valid_q <= release_valid_d;
      if (accept) begin
        id_q       <= grant_id;
        is_write_q <= grant_w;
        row_open_q <= 1'b1;
        open_row_q <= grant_row;
      end
    end
  end

  assign release_valid_o    = release_valid_q;
  assign release_id_o       = id_q;
  assign release_is_write_o = is_write_q;
  assign row_open_o         = row_open_q;
  assign open_row_o         = open_row_q;

  // Burst shape, attributes and in-row offset do not influence timing.
  logic unused_req_fields;
  assign unused_req_fields = ^{waddr_i.len, waddr_i.size, waddr_i.burst,
                               waddr_i.lock, waddr_i.cache, waddr_i.prot,
                               waddr_i.qos, waddr_i.region,
                               waddr_i.addr[RowBufferLenWidth-1:0],
                               raddr_i.len, raddr_i.size, raddr_i.burst,
                               raddr_i.lock, raddr_i.cache, raddr_i.prot,
                               raddr_i.qos, raddr_i.region,
                               raddr_i.addr[RowBufferLenWidth-1:0]};

endmodule

// File: tb/tb_simmem_delay_scheduler.sv
// Scoreboard bench for simmem_delay_scheduler: the driver pushes the expected
// release token (ID, direction, first-valid cycle) at each accepted request;
// a monitor pops and compares whenever a new token appears.
module tb_simmem_delay_scheduler;
  import simmem_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  waddr_req_t           waddr_i = '0;
  logic                 waddr_valid_i = 1'b0;
  logic                 waddr_ready_o;
  raddr_req_t           raddr_i = '0;
  logic                 raddr_valid_i = 1'b0;
  logic                 raddr_ready_o;
  logic                 release_valid_o;
  logic                 release_ready_i = 1'b1;
  logic [IDWidth-1:0]   release_id_o;
  logic                 release_is_write_o;
  logic                 row_open_o;
  logic [RowWidth-1:0]  open_row_o;

  simmem_delay_scheduler dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .waddr_i            (waddr_i),
    .waddr_valid_i      (waddr_valid_i),
    .waddr_ready_o      (waddr_ready_o),
    .raddr_i            (raddr_i),
    .raddr_valid_i      (raddr_valid_i),
    .raddr_ready_o      (raddr_ready_o),
    .release_valid_o    (release_valid_o),
    .release_ready_i    (release_ready_i),
    .release_id_o       (release_id_o),
    .release_is_write_o (release_is_write_o),
    .row_open_o         (row_open_o),
    .open_row_o         (open_row_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [IDWidth-1:0] id;
    logic               wr;
    int                 due;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each new token against the scoreboard, and check that a
  // back-pressured token holds steady and that the two readies never overlap.
  logic               prev_valid = 1'b0;
  logic               prev_ready = 1'b0;
  logic [IDWidth-1:0] prev_id = '0;
  logic               prev_wr = 1'b0;
  exp_t               mon_e;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (release_valid_o && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_release", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("rel_id", release_id_o, mon_e.id);
          check("rel_is_write", release_is_write_o, mon_e.wr);
          check("rel_cycle", cyc, mon_e.due);
        end
      end else if (prev_valid && !prev_ready) begin
        check("hold_valid", release_valid_o, 1'b1);
        check("hold_id", release_id_o, prev_id);
        check("hold_is_write", release_is_write_o, prev_wr);
      end
      if (waddr_ready_o || raddr_ready_o)
        check("one_ready", waddr_ready_o & raddr_ready_o, 1'b0);
    end
    prev_valid = rst_i ? 1'b0 : release_valid_o;
    prev_ready = release_ready_i;
    prev_id    = release_id_o;
    prev_wr    = release_is_write_o;
  end

  // Drive a request; burst/attribute fields are non-zero to show they are ignored.
  task automatic present(input logic wr, input logic [IDWidth-1:0] id,
                         input logic [AxAddrWidth-1:0] addr);
    if (wr) begin
      waddr_i        = '0;
      waddr_i.id     = id;
      waddr_i.addr   = addr;
      waddr_i.len    = 8'd15;
      waddr_i.burst  = 2'b01;
      waddr_i.size   = 3'd3;
      waddr_valid_i  = 1'b1;
    end else begin
      raddr_i        = '0;
      raddr_i.id     = id;
      raddr_i.addr   = addr;
      raddr_i.len    = 8'd7;
      raddr_i.burst  = 2'b10;
      raddr_i.qos    = 4'hf;
      raddr_valid_i  = 1'b1;
    end
  endtask

  // Wait (bounded) for the handshake, push the expected token, drop valid.
  task automatic wait_accept(input logic wr, input logic [IDWidth-1:0] id,
                             input int cost, output int t);
    bit got = 1'b0;
    t = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_i);
      if (wr ? (waddr_valid_i && waddr_ready_o) : (raddr_valid_i && raddr_ready_o)) begin
        got = 1'b1;
        t   = cyc;
        sb.push_back('{id: id, wr: wr, due: cyc + cost + 1});
      end
    end
    check("accept", got, 1'b1);
    @(posedge clk_i);
    #1;
    if (wr) waddr_valid_i = 1'b0;
    else    raddr_valid_i = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [IDWidth-1:0] id,
                       input logic [AxAddrWidth-1:0] addr, input int cost);
    int t;
    @(posedge clk_i);
    #1;
    present(wr, id, addr);
    wait_accept(wr, id, cost, t);
  endtask

  // Wait (bounded) until every expected token has appeared and drained.
  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !release_valid_o) done = 1'b1;
    end
    check("drain", done, 1'b1);
  endtask

  initial begin
    int  n;
    int  t;
    int  u;
    bit  hw;
    bit  hr;
    bit  got;

    // Reset, with a read pending to show ready stays low.
    present(1'b0, 6'd1, 32'h0);
    repeat (3) begin
      @(negedge clk_i);
      check("rst_raddr_ready", raddr_ready_o, 1'b0);
      check("rst_waddr_ready", waddr_ready_o, 1'b0);
    end
    raddr_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_release_valid", release_valid_o, 1'b0);
    check("rst_release_id", release_id_o, '0);
    check("rst_release_is_write", release_is_write_o, 1'b0);
    check("rst_row_open", row_open_o, 1'b0);
    check("rst_open_row", open_row_o, '0);

    // Closed row: activation + hit = 55.
    issue(1'b0, 6'd3, 32'h1234, 55);
    drain();
    check("open_row_after_read", open_row_o, 24'h12);
    check("row_open_after_read", row_open_o, 1'b1);

    // Same row: hit = 10.
    issue(1'b1, 6'd5, 32'h12F0, 10);
    drain();

    // Different row: precharge + activation + hit = 105.
    issue(1'b0, 6'd7, 32'h3400, 105);
    drain();
    check("open_row_after_conflict", open_row_o, 24'h34);

    // Both channels held valid: grants alternate W,R,W,R (all row hits).
    @(posedge clk_i);
    #1;
    present(1'b1, 6'd1, 32'h3410);
    present(1'b0, 6'd2, 32'h3420);
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk_i);
      hw = waddr_valid_i && waddr_ready_o;
      hr = raddr_valid_i && raddr_ready_o;
      if (hw || hr) begin
        check("rr_order_is_write", hw, (n % 2 == 0));
        sb.push_back('{id: (hw ? waddr_i.id : raddr_i.id), wr: hw, due: cyc + 11});
        n++;
        @(posedge clk_i);
        #1;
        if (hw) begin
          if (waddr_i.id == 6'd3) waddr_valid_i = 1'b0;
          else present(1'b1, 6'd3, 32'h3410);
        end
        if (hr) begin
          if (raddr_i.id == 6'd4) raddr_valid_i = 1'b0;
          else present(1'b0, 6'd4, 32'h3420);
        end
      end
    end
    check("rr_grants", n, 4);
    waddr_valid_i = 1'b0;
    raddr_valid_i = 1'b0;
    drain();

    // Back-pressure: token held 20+ cycles, pending read must not be taken.
    @(posedge clk_i);
    #1;
    release_ready_i = 1'b0;
    present(1'b1, 6'd9, 32'h3430);
    wait_accept(1'b1, 6'd9, 10, t);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      if (release_valid_o) got = 1'b1;
    end
    check("bp_token_seen", got, 1'b1);
    @(posedge clk_i);
    #1;
    present(1'b0, 6'd10, 32'h3440);
    repeat (20) begin
      @(negedge clk_i);
      check("bp_valid", release_valid_o, 1'b1);
      check("bp_id", release_id_o, 6'd9);
      check("bp_waddr_ready", waddr_ready_o, 1'b0);
      check("bp_raddr_ready", raddr_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    release_ready_i = 1'b1;
    @(negedge clk_i);
    u = cyc;
    check("rel_hs_valid", release_valid_o, 1'b1);
    check("rel_hs_no_accept", raddr_ready_o, 1'b0);
    wait_accept(1'b0, 6'd10, 10, t);
    check("accept_after_release", t, u + 1);
    drain();

    // Reset mid-SERVE: token dropped, row closed, next request pays 55.
    issue(1'b0, 6'd12, 32'h5000, 105);
    repeat (30) @(negedge clk_i);
    check("mid_serve_no_release", release_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst2_row_open", row_open_o, 1'b0);
    check("rst2_release_valid", release_valid_o, 1'b0);
    check("rst2_open_row", open_row_o, '0);
    repeat (120) @(negedge clk_i);
    issue(1'b1, 6'd13, 32'h5000, 55);
    drain();
    check("row_open_after_rst", row_open_o, 1'b1);
    check("open_row_after_rst", open_row_o, 24'h50);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Last-resort bound in case a wait above is somehow never satisfied.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
